control_pipe: RTL and testbench

Pipelines the decode-stage control bundle through the Execute, Memory and Writeback stages of the 5-stage RISC-V core, and resolves branches in Execute. It also generates the hazard controls for the core: stall/flush signals and operand-forwarding selects. It sits directly downstream of the control unit and feeds the datapath's stage registers, the PC mux and the ALU operand muxes.

---
 rtl/control_pipe_if.sv | 41 ++++
 rtl/control_pipe.sv | 141 ++++++++++++++
 tb/tb_control_pipe.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_pipe_if.sv
// Control-pipeline bundle: decode-stage control in, staged E/M/W control plus hazard/forward controls out.
interface control_pipe_if #(
  parameter int unsigned REG_ADDR_W = 5
);
  logic                  reg_writeD, alu_srcD, mem_writeD, branchD, jumpD;
  logic [1:0]            result_srcD;
  logic [2:0]            alu_controlD, funct3D;
  logic [REG_ADDR_W-1:0] rs1D, rs2D, rdD;
  logic                  zeroE, ltE;

  logic                  reg_writeE, alu_srcE, mem_writeE;
  logic [2:0]            alu_controlE;
  logic [REG_ADDR_W-1:0] rdE, rs1E, rs2E;
  logic                  pc_srcE;
  logic                  reg_writeM, mem_writeM;
  logic [1:0]            result_srcM;
  logic [REG_ADDR_W-1:0] rdM;
  logic                  reg_writeW;
  logic [1:0]            result_srcW;
  logic [REG_ADDR_W-1:0] rdW;
  logic                  stallF, stallD, flushD, flushE;
  logic [1:0]            forward_aE, forward_bE;

  modport master (
    output reg_writeD, alu_srcD, mem_writeD, branchD, jumpD, result_srcD,
           alu_controlD, funct3D, rs1D, rs2D, rdD, zeroE, ltE,
    input  reg_writeE, alu_srcE, mem_writeE, alu_controlE, rdE, rs1E, rs2E,
           pc_srcE, reg_writeM, mem_writeM, result_srcM, rdM,
           reg_writeW, result_srcW, rdW,
           stallF, stallD, flushD, flushE, forward_aE, forward_bE
  );

  modport slave (
    input  reg_writeD, alu_srcD, mem_writeD, branchD, jumpD, result_srcD,
           alu_controlD, funct3D, rs1D, rs2D, rdD, zeroE, ltE,
    output reg_writeE, alu_srcE, mem_writeE, alu_controlE, rdE, rs1E, rs2E,
           pc_srcE, reg_writeM, mem_writeM, result_srcM, rdM,
           reg_writeW, result_srcW, rdW,
           stallF, stallD, flushD, flushE, forward_aE, forward_bE
  );
endinterface

// File: rtl/control_pipe.sv
// E/M/W control pipeline with Execute branch resolution and hazard/forward generation.
// CTRL_FORWARD_EN: defined -> load-use stall + forwarding; undefined -> RAW stall, no forwarding.
module control_pipe #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input logic           clk,
  input logic           reset,
  control_pipe_if.slave bus
);
  typedef enum logic [2:0] {BR_EQ = 3'b000, BR_NE = 3'b001, BR_LT = 3'b100, BR_GE = 3'b101} br_e;
  typedef enum logic [1:0] {RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10} res_e;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_e;

  logic                  r_reg_writeE, r_mem_writeE, r_jumpE, r_branchE, r_alu_srcE;
  logic [1:0]            r_result_srcE;
  logic [2:0]            r_alu_controlE, r_funct3E;
  logic [REG_ADDR_W-1:0] r_rdE, r_rs1E, r_rs2E;
  logic                  r_reg_writeM, r_mem_writeM;
  logic [1:0]            r_result_srcM;
  logic [REG_ADDR_W-1:0] r_rdM;
  logic                  r_reg_writeW;
  logic [1:0]            r_result_srcW;
  logic [REG_ADDR_W-1:0] r_rdW;

  logic w_cond, w_pc_src, w_data_stall, w_flushE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reg_writeE   <= 1'b0;
      r_mem_writeE   <= 1'b0;
      r_jumpE        <= 1'b0;
      r_branchE      <= 1'b0;
      r_alu_srcE     <= 1'b0;
      r_result_srcE  <= '0;
      r_alu_controlE <= '0;
      r_funct3E      <= '0;
      r_rdE          <= '0;
      r_rs1E         <= '0;
      r_rs2E         <= '0;
      r_reg_writeM   <= 1'b0;
      r_mem_writeM   <= 1'b0;
      r_result_srcM  <= '0;
      r_rdM          <= '0;
      r_reg_writeW   <= 1'b0;
      r_result_srcW  <= '0;
      r_rdW          <= '0;
    end else begin
      // A flushed E slot becomes an all-zero bubble; M and W always advance.
      if (w_flushE) begin
        r_reg_writeE   <= 1'b0;
        r_mem_writeE   <= 1'b0;
        r_jumpE        <= 1'b0;
        r_branchE      <= 1'b0;
        r_alu_srcE     <= 1'b0;
        r_result_srcE  <= '0;
        r_alu_controlE <= '0;
        r_funct3E      <= '0;
        r_rdE          <= '0;
        r_rs1E         <= '0;
        r_rs2E         <= '0;
      end else begin
        r_reg_writeE   <= bus.reg_writeD;
        r_mem_writeE   <= bus.mem_writeD;
        r_jumpE        <= bus.jumpD;
        r_branchE      <= bus.branchD;
        r_alu_srcE     <= bus.alu_srcD;
        r_result_srcE  <= bus.result_srcD;
        r_alu_controlE <= bus.alu_controlD;
        r_funct3E      <= bus.funct3D;
        r_rdE          <= bus.rdD;
        r_rs1E         <= bus.rs1D;
        r_rs2E         <= bus.rs2D;
      end
      r_reg_writeM  <= r_reg_writeE;
      r_mem_writeM  <= r_mem_writeE;
      r_result_srcM <= r_result_srcE;
      r_rdM         <= r_rdE;
      r_reg_writeW  <= r_reg_writeM;
      r_result_srcW <= r_result_srcM;
      r_rdW         <= r_rdM;
    end
  end

  always_comb begin
    w_cond = 1'b0;
    case (r_funct3E)
      BR_EQ:   w_cond = bus.zeroE;
      BR_NE:   w_cond = ~bus.zeroE;
      BR_LT:   w_cond = bus.ltE;
      BR_GE:   w_cond = ~bus.ltE;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_pc_src = r_jumpE | (r_branchE & w_cond);

`ifdef CTRL_FORWARD_EN
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
    if (rs != '0 && r_reg_writeM && r_rdM == rs)      return FWD_MEM;
    else if (rs != '0 && r_reg_writeW && r_rdW == rs) return FWD_WB;
    else                                              return FWD_RF;
  endfunction

  assign w_data_stall = (r_result_srcE == RES_MEM) && (r_rdE != '0) &&
                        ((r_rdE == bus.rs1D) || (r_rdE == bus.rs2D));
  assign bus.forward_aE = fwd_sel(r_rs1E);
  assign bus.forward_bE = fwd_sel(r_rs2E);
`else
  // Without forwarding, wait until the producer reaches W (register file writes on the falling edge).
  function automatic logic raw_hit(input logic [REG_ADDR_W-1:0] rs);
    return (rs != '0) && ((r_reg_writeE && r_rdE == rs) || (r_reg_writeM && r_rdM == rs));
  endfunction

  assign w_data_stall   = raw_hit(bus.rs1D) | raw_hit(bus.rs2D);
  assign bus.forward_aE = FWD_RF;
  assign bus.forward_bE = FWD_RF;
`endif

  // A taken branch squashes D, so a simultaneous data stall is dropped.
  assign w_flushE   = w_pc_src | w_data_stall;
  assign bus.stallF = w_data_stall & ~w_pc_src;
  assign bus.stallD = w_data_stall & ~w_pc_src;
  assign bus.flushD = w_pc_src;
  assign bus.flushE = w_flushE;
  assign bus.pc_srcE = w_pc_src;

  assign bus.reg_writeE   = r_reg_writeE;
  assign bus.alu_srcE     = r_alu_srcE;
  assign bus.mem_writeE   = r_mem_writeE;
  assign bus.alu_controlE = r_alu_controlE;
  assign bus.rdE          = r_rdE;
  assign bus.rs1E         = r_rs1E;
  assign bus.rs2E         = r_rs2E;
  assign bus.reg_writeM   = r_reg_writeM;
  assign bus.mem_writeM   = r_mem_writeM;
  assign bus.result_srcM  = r_result_srcM;
  assign bus.rdM          = r_rdM;
  assign bus.reg_writeW   = r_reg_writeW;
  assign bus.result_srcW  = r_result_srcW;
  assign bus.rdW          = r_rdW;
endmodule

// File: tb/tb_control_pipe.sv
// Randomized bench for control_pipe: a shift-array model of the E/M/W slots plus directed literal checks.
module tb_control_pipe;
  logic clk;
  logic reset;
  int unsigned tests = 0;
  int unsigned fails = 0;
  bit chk_en = 0;

`ifdef CTRL_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  control_pipe_if #(.REG_ADDR_W(5)) bus ();
  control_pipe #(.REG_ADDR_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rw;
    logic [1:0] rsrc;
    logic       mw, jmp, br;
    logic [2:0] alu;
    logic       asrc;
    logic [2:0] f3;
    logic [4:0] rd, rs1, rs2;
  } bundle_t;

  // pipe[0]=E, pipe[1]=M, pipe[2]=W
  bundle_t pipe [3];

  function automatic bundle_t d_bundle();
    bundle_t b;
    b.rw = bus.reg_writeD; b.rsrc = bus.result_srcD; b.mw = bus.mem_writeD;
    b.jmp = bus.jumpD; b.br = bus.branchD; b.alu = bus.alu_controlD;
    b.asrc = bus.alu_srcD; b.f3 = bus.funct3D;
    b.rd = bus.rdD; b.rs1 = bus.rs1D; b.rs2 = bus.rs2D;
    return b;
  endfunction

  function automatic bit m_taken();
    bit c;
    case (pipe[0].f3)
      3'd0:    c = bus.zeroE;
      3'd1:    c = !bus.zeroE;
      3'd4:    c = bus.ltE;
      3'd5:    c = !bus.ltE;
      default: c = 1'b0;
    endcase
    return pipe[0].jmp || (pipe[0].br && c);
  endfunction

  function automatic bit m_depends(input logic [4:0] rd);
    return rd != 0 && (rd == bus.rs1D || rd == bus.rs2D);
  endfunction

  function automatic bit m_data_stall();
    if (FWD_EN) return pipe[0].rsrc == 2'b01 && m_depends(pipe[0].rd);
    return (pipe[0].rw && m_depends(pipe[0].rd)) || (pipe[1].rw && m_depends(pipe[1].rd));
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (!FWD_EN || rs == 0) return 2'b00;
    if (pipe[1].rw && pipe[1].rd == rs) return 2'b10;
    if (pipe[2].rw && pipe[2].rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe[0] <= '0; pipe[1] <= '0; pipe[2] <= '0;
    end else begin
      pipe[0] <= (m_taken() || m_data_stall()) ? '0 : d_bundle();
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      bit tk, st;
      tk = m_taken();
      st = m_data_stall();
      check("reg_writeE",   32'(bus.reg_writeE),   32'(pipe[0].rw));
      check("alu_srcE",     32'(bus.alu_srcE),     32'(pipe[0].asrc));
      check("mem_writeE",   32'(bus.mem_writeE),   32'(pipe[0].mw));
      check("alu_controlE", 32'(bus.alu_controlE), 32'(pipe[0].alu));
      check("rdE",          32'(bus.rdE),          32'(pipe[0].rd));
      check("rs1E",         32'(bus.rs1E),         32'(pipe[0].rs1));
      check("rs2E",         32'(bus.rs2E),         32'(pipe[0].rs2));
      check("reg_writeM",   32'(bus.reg_writeM),   32'(pipe[1].rw));
      check("mem_writeM",   32'(bus.mem_writeM),   32'(pipe[1].mw));
      check("result_srcM",  32'(bus.result_srcM),  32'(pipe[1].rsrc));
      check("rdM",          32'(bus.rdM),          32'(pipe[1].rd));
      check("reg_writeW",   32'(bus.reg_writeW),   32'(pipe[2].rw));
      check("result_srcW",  32'(bus.result_srcW),  32'(pipe[2].rsrc));
      check("rdW",          32'(bus.rdW),          32'(pipe[2].rd));
      check("pc_srcE",      32'(bus.pc_srcE),      32'(tk));
      check("stallF",       32'(bus.stallF),       32'(st && !tk));
      check("stallD",       32'(bus.stallD),       32'(st && !tk));
      check("flushD",       32'(bus.flushD),       32'(tk));
      check("flushE",       32'(bus.flushE),       32'(tk || st));
      check("forward_aE",   32'(bus.forward_aE),   32'(m_fwd(pipe[0].rs1)));
      check("forward_bE",   32'(bus.forward_bE),   32'(m_fwd(pipe[0].rs2)));
    end
  end

  task automatic set_all_d(input logic v);
    bus.reg_writeD = v; bus.alu_srcD = v; bus.mem_writeD = v; bus.branchD = v; bus.jumpD = v;
    bus.result_srcD = {2{v}}; bus.alu_controlD = {3{v}}; bus.funct3D = {3{v}};
    bus.rs1D = {5{v}}; bus.rs2D = {5{v}}; bus.rdD = {5{v}};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    set_all_d(1'b0);
    bus.zeroE = 1'b0; bus.ltE = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b1;
    set_all_d(1'b1);
    bus.zeroE = 1'b1; bus.ltE = 1'b1;
    #2;
    check("rst_reg_writeE", 32'(bus.reg_writeE), 0);
    check("rst_rdE",        32'(bus.rdE),        0);
    check("rst_rdM",        32'(bus.rdM),        0);
    check("rst_rdW",        32'(bus.rdW),        0);
    check("rst_reg_writeW", 32'(bus.reg_writeW), 0);
    check("rst_pc_srcE",    32'(bus.pc_srcE),    0);
    check("rst_stallF",     32'(bus.stallF),     0);
    check("rst_flushD",     32'(bus.flushD),     0);
    check("rst_flushE",     32'(bus.flushE),     0);
    check("rst_forward_aE", 32'(bus.forward_aE), 0);
    chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    drain();

    // Stage latency of a single write to x7.
    bus.reg_writeD = 1'b1; bus.rdD = 5'd7;
    tick(); set_all_d(1'b0); #1;
    check("lat_rdE", 32'(bus.rdE), 7);
    tick(); #1;
    check("lat_rdM", 32'(bus.rdM), 7);
    tick(); #1;
    check("lat_rdW", 32'(bus.rdW), 7);
    check("lat_reg_writeW", 32'(bus.reg_writeW), 1);
    drain();

    // Load to x5 followed by a use of x5.
    bus.reg_writeD = 1'b1; bus.result_srcD = 2'b01; bus.rdD = 5'd5;
    tick(); set_all_d(1'b0); bus.rs1D = 5'd5; #1;
    check("lu_stallF", 32'(bus.stallF), 1);
    check("lu_stallD", 32'(bus.stallD), 1);
    check("lu_flushE", 32'(bus.flushE), 1);
    check("lu_flushD", 32'(bus.flushD), 0);
    tick(); #1;
    check("lu_bubble_reg_writeE", 32'(bus.reg_writeE), 0);
    check("lu_bubble_rdE", 32'(bus.rdE), 0);
    check("lu_stallF_after", 32'(bus.stallF), FWD_EN ? 0 : 1);
    drain();

    // bne taken (zeroE=0) then not taken (zeroE=1).
    bus.branchD = 1'b1; bus.funct3D = 3'b001;
    tick(); set_all_d(1'b0); bus.zeroE = 1'b0; #1;
    check("bne_pc_srcE", 32'(bus.pc_srcE), 1);
    check("bne_flushD",  32'(bus.flushD),  1);
    check("bne_flushE",  32'(bus.flushE),  1);
    bus.reg_writeD = 1'b1; bus.rdD = 5'd9;
    tick(); #1;
    check("bne_bubble_rdE", 32'(bus.rdE), 0);
    check("bne_bubble_pc_srcE", 32'(bus.pc_srcE), 0);
    drain();
    bus.branchD = 1'b1; bus.funct3D = 3'b001;
    tick(); set_all_d(1'b0); bus.zeroE = 1'b1; #1;
    check("bne_nt_pc_srcE", 32'(bus.pc_srcE), 0);
    check("bne_nt_flushD",  32'(bus.flushD),  0);
    bus.reg_writeD = 1'b1; bus.rdD = 5'd9;
    tick(); #1;
    check("bne_nt_rdE", 32'(bus.rdE), 9);
    drain();

    // Writes to x3 in M and W, then rs1E=3.
    bus.reg_writeD = 1'b1; bus.rdD = 5'd3;
    tick(); tick();
    set_all_d(1'b0); bus.rs1D = 5'd3;
    tick(); #1;
    check("fwd_a_mem", 32'(bus.forward_aE), FWD_EN ? 2 : 0);
    check("fwd_b_rf",  32'(bus.forward_bE), 0);
    drain();
    bus.reg_writeD = 1'b1; bus.rdD = 5'd3;
    tick(); bus.reg_writeD = 1'b0;
    tick(); set_all_d(1'b0); bus.rs1D = 5'd3;
    tick(); #1;
    check("fwd_a_wb", 32'(bus.forward_aE), FWD_EN ? 1 : 0);
    drain();

    // Load-use coinciding with a taken jump: flush wins.
    bus.jumpD = 1'b1; bus.reg_writeD = 1'b1; bus.result_srcD = 2'b01; bus.rdD = 5'd5;
    tick(); set_all_d(1'b0); bus.rs1D = 5'd5; #1;
    check("both_flushD", 32'(bus.flushD), 1);
    check("both_flushE", 32'(bus.flushE), 1);
    check("both_stallF", 32'(bus.stallF), 0);
    check("both_stallD", 32'(bus.stallD), 0);
    drain();

    // ALU write to x4 then rs2D=4.
    bus.reg_writeD = 1'b1; bus.rdD = 5'd4;
    tick(); set_all_d(1'b0); bus.rs2D = 5'd4; #1;
    check("raw_stall_c1", 32'(bus.stallF), FWD_EN ? 0 : 1);
    tick(); #1;
    check("raw_stall_c2", 32'(bus.stallF), FWD_EN ? 0 : 1);
    tick(); #1;
    check("raw_stall_c3", 32'(bus.stallF), 0);
    drain();

    for (int i = 0; i < 3000; i++) begin
      bus.reg_writeD   = 1'($urandom);
      bus.alu_srcD     = 1'($urandom);
      bus.mem_writeD   = 1'($urandom);
      bus.branchD      = 1'($urandom);
      bus.jumpD        = ($urandom_range(0, 7) == 0);
      bus.result_srcD  = 2'($urandom_range(0, 2));
      bus.alu_controlD = 3'($urandom);
      bus.funct3D      = 3'($urandom);
      bus.rs1D         = 5'($urandom_range(0, 7));
      bus.rs2D         = 5'($urandom_range(0, 7));
      bus.rdD          = 5'($urandom_range(0, 7));
      bus.zeroE        = 1'($urandom);
      bus.ltE          = 1'($urandom);
      if (i == 1500) begin
        reset = 1'b1;
        #1;
        check("midrst_rdE",     32'(bus.rdE),     0);
        check("midrst_rdW",     32'(bus.rdW),     0);
        check("midrst_pc_srcE", 32'(bus.pc_srcE), 0);
        check("midrst_flushE",  32'(bus.flushE),  0);
        #1 reset = 1'b0;
      end
      tick();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
